// File: rtl/cpu_types_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : cpu_types_pkg
//  Purpose  : Shared CPU types and constants for the fetch pipeline.
//  Revision : 1.0 - initial release
// ============================================================================
package cpu_types_pkg;

   typedef logic [31:0] word_t;

   typedef enum logic [1:0] {
      BOOT   = 2'b00,
      FETCH  = 2'b01,
      HALTED = 2'b10
   } fetch_state_t;

   localparam logic [5:0] c_HALT_OPCODE = 6'b111111;
   localparam logic [1:0] c_PCSRC_JR    = 2'b11;
   localparam word_t      c_PC_STEP     = 32'd4;

   function automatic logic is_halt(input logic [5:0] opcode);
      return (opcode == c_HALT_OPCODE);
   endfunction

endpackage
`default_nettype wire

// File: rtl/ifid_latch.sv
`default_nettype none
// ============================================================================
//  Module   : ifid_latch
//  Purpose  : IF/ID pipeline register with hold, bubble and load controls.
//  Revision : 1.0 - initial release
// ============================================================================
module ifid_latch
   import cpu_types_pkg::*;
(
   input  logic  clk,
   input  logic  rst,
   input  logic  hold,
   input  logic  bubble,
   input  logic  load,
   input  word_t instr_in,
   input  word_t npc_in,
   output word_t instr_out,
   output word_t npc_out,
   output logic  valid_out
);

   word_t r_instr;
   word_t r_npc;
   logic  r_valid;

   // hold outranks bubble, bubble outranks load
   always_ff @(posedge clk) begin
      if (rst) begin
         r_instr <= '0;
         r_npc   <= '0;
         r_valid <= 1'b0;
      end else if (hold) begin
         r_instr <= r_instr;
         r_npc   <= r_npc;
         r_valid <= r_valid;
      end else if (bubble) begin
         r_instr <= '0;
         r_npc   <= '0;
         r_valid <= 1'b0;
      end else if (load) begin
         r_instr <= instr_in;
         r_npc   <= npc_in;
         r_valid <= 1'b1;
      end
   end

   assign instr_out = r_instr;
   assign npc_out   = r_npc;
   assign valid_out = r_valid;

endmodule
`default_nettype wire

// File: rtl/fetch_stage.sv
`default_nettype none
// ============================================================================
//  Module   : fetch_stage
//  Purpose  : Instruction fetch: PC register, boot/fetch/halt FSM, IF/ID latch.
//  Revision : 1.0 - initial release
// ============================================================================
module fetch_stage
   import cpu_types_pkg::*;
#(
   parameter word_t PC_INIT = 32'h0000_0000
)
(
   input  logic       CLK,
   input  logic       RST,
   input  logic       ihit,
   input  word_t      imemload,
   output logic       imemREN,
   output word_t      imemaddr,
   input  logic       mem_stall,
   input  logic       lw_nop,
   input  logic       jmp_flush,
   input  logic       brch_flush,
   input  logic [1:0] idex_pcsrc_out,
   input  word_t      brch_target,
   input  word_t      jmp_target,
   input  word_t      jr_target,
   output word_t      ifid_instr_out,
   output word_t      ifid_npc_out,
   output logic       ifid_valid_out
);

   fetch_state_t r_state;
   fetch_state_t w_state_nxt;
   word_t        r_pc;
   word_t        w_pc_nxt;
   word_t        w_pc_plus4;
   word_t        w_target;
   logic         w_flush;
   logic         w_halt_word;
   logic         w_ifid_bubble;
   logic         w_ifid_load;

   assign w_flush     = brch_flush | jmp_flush;
   assign w_pc_plus4  = r_pc + c_PC_STEP;
   assign w_halt_word = is_halt(imemload[31:26]);

   always_comb begin
      w_target = jmp_target;
      if (brch_flush)
         w_target = brch_target;
      else if (idex_pcsrc_out == c_PCSRC_JR)
         w_target = jr_target;
   end

   always_comb begin
      w_state_nxt   = r_state;
      w_pc_nxt      = r_pc;
      w_ifid_bubble = 1'b0;
      w_ifid_load   = 1'b0;
      if (mem_stall) begin
         w_state_nxt = r_state;
      end else if (r_state == BOOT) begin
         w_state_nxt = FETCH;
      end else if (w_flush) begin
         w_pc_nxt      = w_target;
         w_ifid_bubble = 1'b1;
         w_state_nxt   = FETCH;
      end else if (r_state == FETCH) begin
         if (lw_nop) begin
            // word is discarded and refetched once the load-use stall clears
            w_pc_nxt = r_pc;
         end else if (ihit) begin
            w_ifid_load = 1'b1;
            if (w_halt_word)
               w_state_nxt = HALTED;
            else
               w_pc_nxt = w_pc_plus4;
         end else begin
            w_ifid_bubble = 1'b1;
         end
      end else if (r_state != HALTED) begin
         w_state_nxt = BOOT;
      end
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         r_state <= BOOT;
         r_pc    <= PC_INIT;
      end else begin
         r_state <= w_state_nxt;
         r_pc    <= w_pc_nxt;
      end
   end

   assign imemREN  = (r_state == FETCH);
   assign imemaddr = r_pc;

   ifid_latch u_ifid_latch (
      .clk       (CLK),
      .rst       (RST),
      .hold      (mem_stall),
      .bubble    (w_ifid_bubble),
      .load      (w_ifid_load),
      .instr_in  (imemload),
      .npc_in    (w_pc_plus4),
      .instr_out (ifid_instr_out),
      .npc_out   (ifid_npc_out),
      .valid_out (ifid_valid_out)
   );

endmodule
`default_nettype wire

// File: tb/tb_fetch_stage.sv
`default_nettype none
// ============================================================================
//  Module   : tb_fetch_stage
//  Purpose  : Directed self-checking bench for fetch_stage (PC_INIT = 0x200).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_fetch_stage;

   logic        CLK = 1'b0;
   logic        RST;
   logic        ihit;
   logic [31:0] imemload;
   logic        imemREN;
   logic [31:0] imemaddr;
   logic        mem_stall;
   logic        lw_nop;
   logic        jmp_flush;
   logic        brch_flush;
   logic [1:0]  idex_pcsrc_out;
   logic [31:0] brch_target;
   logic [31:0] jmp_target;
   logic [31:0] jr_target;
   logic [31:0] ifid_instr_out;
   logic [31:0] ifid_npc_out;
   logic        ifid_valid_out;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 CLK = ~CLK;

   fetch_stage #(.PC_INIT(32'h0000_0200)) dut (
      .CLK            (CLK),
      .RST            (RST),
      .ihit           (ihit),
      .imemload       (imemload),
      .imemREN        (imemREN),
      .imemaddr       (imemaddr),
      .mem_stall      (mem_stall),
      .lw_nop         (lw_nop),
      .jmp_flush      (jmp_flush),
      .brch_flush     (brch_flush),
      .idex_pcsrc_out (idex_pcsrc_out),
      .brch_target    (brch_target),
      .jmp_target     (jmp_target),
      .jr_target      (jr_target),
      .ifid_instr_out (ifid_instr_out),
      .ifid_npc_out   (ifid_npc_out),
      .ifid_valid_out (ifid_valid_out)
   );

   task automatic cyc();
      @(posedge CLK);
      #1;
   endtask

   task automatic idle();
      ihit = 1'b0; imemload = '0; mem_stall = 1'b0; lw_nop = 1'b0;
      jmp_flush = 1'b0; brch_flush = 1'b0; idex_pcsrc_out = 2'b00;
      brch_target = '0; jmp_target = '0; jr_target = '0;
   endtask

   task automatic goto_pc(input logic [31:0] addr);
      idle();
      brch_flush = 1'b1; brch_target = addr;
      cyc();
      idle();
   endtask

   task automatic test_reset();
      idle();
      RST = 1'b1; ihit = 1'b1; imemload = 32'hDEAD_BEEF; mem_stall = 1'b1;
      cyc(); cyc();
      n_checks++; if (imemREN !== 1'b0) begin n_fail++; $display("FAIL rst_ren: got %b expected 0", imemREN); end
      n_checks++; if (imemaddr !== 32'h200) begin n_fail++; $display("FAIL rst_pc: got %h expected 00000200", imemaddr); end
      n_checks++; if ({ifid_instr_out, ifid_npc_out, ifid_valid_out} !== 65'd0) begin n_fail++; $display("FAIL rst_ifid: got %h %h %b expected zeros", ifid_instr_out, ifid_npc_out, ifid_valid_out); end
      RST = 1'b0; mem_stall = 1'b0; imemload = 32'h1111_1111;
      #1;
      n_checks++; if (imemREN !== 1'b0) begin n_fail++; $display("FAIL boot_ren: got %b expected 0", imemREN); end
      cyc();
      n_checks++; if (imemREN !== 1'b1) begin n_fail++; $display("FAIL fetch_ren: got %b expected 1", imemREN); end
      n_checks++; if (imemaddr !== 32'h200) begin n_fail++; $display("FAIL boot_pc_hold: got %h expected 00000200", imemaddr); end
      n_checks++; if (ifid_valid_out !== 1'b0) begin n_fail++; $display("FAIL boot_ihit_ignored: got valid %b expected 0", ifid_valid_out); end
   endtask

   task automatic test_sequential();
      ihit = 1'b1; imemload = 32'h0000_00A1;
      cyc();
      n_checks++; if (imemaddr !== 32'h204) begin n_fail++; $display("FAIL seq_pc1: got %h expected 00000204", imemaddr); end
      n_checks++; if ({ifid_instr_out, ifid_npc_out, ifid_valid_out} !== {32'h0000_00A1, 32'h204, 1'b1}) begin n_fail++; $display("FAIL seq_ifid1: got %h %h %b expected 000000a1 00000204 1", ifid_instr_out, ifid_npc_out, ifid_valid_out); end
      imemload = 32'h0000_00B2;
      cyc();
      n_checks++; if (imemaddr !== 32'h208) begin n_fail++; $display("FAIL seq_pc2: got %h expected 00000208", imemaddr); end
      n_checks++; if ({ifid_instr_out, ifid_npc_out} !== {32'h0000_00B2, 32'h208}) begin n_fail++; $display("FAIL seq_ifid2: got %h %h expected 000000b2 00000208", ifid_instr_out, ifid_npc_out); end
      idle();
   endtask

   task automatic test_miss_and_wrap();
      goto_pc(32'hFFFF_FFFC);
      ihit = 1'b1; imemload = 32'h0000_0C0C;
      cyc();
      n_checks++; if (imemaddr !== 32'h0) begin n_fail++; $display("FAIL wrap_pc: got %h expected 00000000", imemaddr); end
      n_checks++; if ({ifid_npc_out, ifid_valid_out} !== {32'h0, 1'b1}) begin n_fail++; $display("FAIL wrap_npc: got %h %b expected 00000000 1", ifid_npc_out, ifid_valid_out); end
      ihit = 1'b0; imemload = 32'h5555_5555;
      for (int i = 0; i < 3; i++) begin
         cyc();
         n_checks++; if (imemaddr !== 32'h0) begin n_fail++; $display("FAIL miss_pc%0d: got %h expected 00000000", i, imemaddr); end
         n_checks++; if ({ifid_instr_out, ifid_npc_out, ifid_valid_out} !== 65'd0) begin n_fail++; $display("FAIL miss_bubble%0d: got %h %h %b expected zeros", i, ifid_instr_out, ifid_npc_out, ifid_valid_out); end
      end
      ihit = 1'b1; imemload = 32'h2345_6789;
      cyc();
      n_checks++; if (imemaddr !== 32'h4) begin n_fail++; $display("FAIL miss_then_hit_pc: got %h expected 00000004", imemaddr); end
      n_checks++; if ({ifid_instr_out, ifid_npc_out, ifid_valid_out} !== {32'h2345_6789, 32'h4, 1'b1}) begin n_fail++; $display("FAIL miss_then_hit_ifid: got %h %h %b expected 23456789 00000004 1", ifid_instr_out, ifid_npc_out, ifid_valid_out); end
      idle();
   endtask

   task automatic test_lw_nop();
      goto_pc(32'h0C);
      ihit = 1'b1; imemload = 32'hAAAA_0001;
      cyc();
      lw_nop = 1'b1; imemload = 32'hBBBB_0002;
      cyc();
      n_checks++; if (imemaddr !== 32'h10) begin n_fail++; $display("FAIL lwnop_pc: got %h expected 00000010", imemaddr); end
      n_checks++; if ({ifid_instr_out, ifid_npc_out, ifid_valid_out} !== {32'hAAAA_0001, 32'h10, 1'b1}) begin n_fail++; $display("FAIL lwnop_ifid_hold: got %h %h %b expected aaaa0001 00000010 1", ifid_instr_out, ifid_npc_out, ifid_valid_out); end
      lw_nop = 1'b0;
      cyc();
      n_checks++; if (imemaddr !== 32'h14) begin n_fail++; $display("FAIL lwnop_release_pc: got %h expected 00000014", imemaddr); end
      n_checks++; if ({ifid_instr_out, ifid_npc_out} !== {32'hBBBB_0002, 32'h14}) begin n_fail++; $display("FAIL lwnop_refetch: got %h %h expected bbbb0002 00000014", ifid_instr_out, ifid_npc_out); end
      idle();
   endtask

   task automatic test_flush();
      goto_pc(32'h1C);
      ihit = 1'b1; imemload = 32'h1234_0000;
      cyc();
      brch_flush = 1'b1; brch_target = 32'h80; lw_nop = 1'b1; imemload = 32'h9999_9999;
      cyc();
      n_checks++; if (imemaddr !== 32'h80) begin n_fail++; $display("FAIL brch_pc: got %h expected 00000080", imemaddr); end
      n_checks++; if ({ifid_instr_out, ifid_npc_out, ifid_valid_out} !== 65'd0) begin n_fail++; $display("FAIL brch_bubble: got %h %h %b expected zeros", ifid_instr_out, ifid_npc_out, ifid_valid_out); end
      idle();
      jmp_flush = 1'b1; idex_pcsrc_out = 2'b11; jr_target = 32'h44; jmp_target = 32'h99C; ihit = 1'b1;
      cyc();
      n_checks++; if (imemaddr !== 32'h44) begin n_fail++; $display("FAIL jr_pc: got %h expected 00000044", imemaddr); end
      idex_pcsrc_out = 2'b10; jmp_target = 32'h300;
      cyc();
      n_checks++; if (imemaddr !== 32'h300) begin n_fail++; $display("FAIL jmp_pc: got %h expected 00000300", imemaddr); end
      brch_flush = 1'b1; brch_target = 32'h600; idex_pcsrc_out = 2'b11; jr_target = 32'h700;
      cyc();
      n_checks++; if (imemaddr !== 32'h600) begin n_fail++; $display("FAIL brch_over_jr: got %h expected 00000600", imemaddr); end
      idle();
   endtask

   task automatic test_halt();
      goto_pc(32'h30);
      ihit = 1'b1; imemload = 32'hFC00_0000;
      cyc();
      n_checks++; if (imemREN !== 1'b0) begin n_fail++; $display("FAIL halt_ren: got %b expected 0", imemREN); end
      n_checks++; if (imemaddr !== 32'h30) begin n_fail++; $display("FAIL halt_pc: got %h expected 00000030", imemaddr); end
      n_checks++; if ({ifid_instr_out, ifid_npc_out, ifid_valid_out} !== {32'hFC00_0000, 32'h34, 1'b1}) begin n_fail++; $display("FAIL halt_ifid: got %h %h %b expected fc000000 00000034 1", ifid_instr_out, ifid_npc_out, ifid_valid_out); end
      imemload = 32'h1234_5678;
      cyc();
      n_checks++; if ({imemaddr, ifid_instr_out, imemREN} !== {32'h30, 32'hFC00_0000, 1'b0}) begin n_fail++; $display("FAIL halted_hold: got %h %h %b expected 00000030 fc000000 0", imemaddr, ifid_instr_out, imemREN); end
      ihit = 1'b0; brch_flush = 1'b1; brch_target = 32'h100;
      cyc();
      n_checks++; if ({imemREN, imemaddr} !== {1'b1, 32'h100}) begin n_fail++; $display("FAIL halt_exit: got %b %h expected 1 00000100", imemREN, imemaddr); end
      n_checks++; if (ifid_valid_out !== 1'b0) begin n_fail++; $display("FAIL halt_exit_bubble: got %b expected 0", ifid_valid_out); end
      idle();
   endtask

   task automatic test_mem_stall();
      goto_pc(32'h1FC);
      ihit = 1'b1; imemload = 32'h5A5A_0001;
      cyc();
      mem_stall = 1'b1; brch_flush = 1'b1; brch_target = 32'h400; imemload = 32'h5A5A_0002;
      cyc(); cyc();
      n_checks++; if ({imemREN, imemaddr} !== {1'b1, 32'h200}) begin n_fail++; $display("FAIL stall_pc: got %b %h expected 1 00000200", imemREN, imemaddr); end
      n_checks++; if ({ifid_instr_out, ifid_npc_out, ifid_valid_out} !== {32'h5A5A_0001, 32'h200, 1'b1}) begin n_fail++; $display("FAIL stall_ifid: got %h %h %b expected 5a5a0001 00000200 1", ifid_instr_out, ifid_npc_out, ifid_valid_out); end
      mem_stall = 1'b0;
      cyc();
      n_checks++; if (imemaddr !== 32'h400) begin n_fail++; $display("FAIL stall_release_pc: got %h expected 00000400", imemaddr); end
      n_checks++; if (ifid_valid_out !== 1'b0) begin n_fail++; $display("FAIL stall_release_bubble: got %b expected 0", ifid_valid_out); end
      idle();
   endtask

   task automatic test_reset_mid_halt();
      goto_pc(32'h50);
      ihit = 1'b1; imemload = 32'hFC00_0001;
      cyc();
      RST = 1'b1; mem_stall = 1'b1;
      cyc();
      n_checks++; if ({imemREN, imemaddr} !== {1'b0, 32'h200}) begin n_fail++; $display("FAIL rst_halt_pc: got %b %h expected 0 00000200", imemREN, imemaddr); end
      n_checks++; if ({ifid_instr_out, ifid_npc_out, ifid_valid_out} !== 65'd0) begin n_fail++; $display("FAIL rst_halt_ifid: got %h %h %b expected zeros", ifid_instr_out, ifid_npc_out, ifid_valid_out); end
      RST = 1'b0; mem_stall = 1'b0; brch_flush = 1'b1; brch_target = 32'h500;
      cyc();
      n_checks++; if ({imemREN, imemaddr} !== {1'b1, 32'h200}) begin n_fail++; $display("FAIL boot_ignores_flush: got %b %h expected 1 00000200", imemREN, imemaddr); end
      idle();
   endtask

   initial begin
      RST = 1'b1;
      idle();
      test_reset();
      test_sequential();
      test_miss_and_wrap();
      test_lw_nop();
      test_flush();
      test_halt();
      test_mem_stall();
      test_reset_mid_halt();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
